sys_ctrl_gen2: RTL

Second-generation system controller between the UART RX/TX byte path, register file, ALU and TX FIFO. It decodes the single-access command frames and adds burst register-file read and write with address auto-increment. It also sends ALU results of any byte multiple, LSB first, with lossless FIFO back-pressure. An RX inactivity timeout aborts stalled frames and raises a one-cycle error pulse.

---
 rtl/sys_ctrl_gen2.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sys_ctrl_gen2.sv
// System controller: decodes UART command frames into register-file, ALU and
// TX FIFO traffic, with burst RF access and an RX inactivity timeout.
module sys_ctrl_gen2 #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR          = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int BURST_MAX     = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     Out_Valid,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [DATA_WIDTH-1:0]    RX_P_Data,
  input  logic                     RX_D_VLD,
  input  logic                     FIFO_Full,
  output logic [3:0]               ALU_FUN,
  output logic                     ALU_EN,
  output logic                     CLK_EN,
  output logic [ADDR-1:0]          Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     clk_div_en,
  output logic                     Cmd_Err
);

  // state            | meaning
  // IDLE             | waiting for a command byte
  // WR_*/RD_*/TX_RD  | single write, single read, read-data transmit
  // OP_*/ALU_*       | operand writes, function byte, result wait/transmit
  // BW_*/BR_*        | burst write / burst read (BR_RD issues each read)
  typedef enum logic [4:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD,
    OP_A, OP_B, ALU_FN, ALU_WAIT, TX_ALU,
    BW_ADDR, BW_LEN, BW_DATA, BR_ADDR, BR_LEN, BR_RD
  } state_t;

  localparam int NB    = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int K_W   = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FN = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] CMD_BW = DATA_WIDTH'(8'hEE);
  localparam logic [DATA_WIDTH-1:0] CMD_BR = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] L_MAX  = DATA_WIDTH'(BURST_MAX);

  localparam logic [ADDR-1:0]  ADDR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [K_W-1:0]   K_ONE    = 1;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(NB - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic [ADDR-1:0]          addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    rd_buf_q, rd_buf_d;
  logic [ALU_OUT_WIDTH-1:0] res_q, res_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     burst_q, burst_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic                     err_q, err_d;
  logic                     wait_rx;
  logic                     len_ok;
  logic [DATA_WIDTH-1:0]    alu_byte;

  assign clk_div_en = 1'b1;
  assign Cmd_Err    = err_q;
  assign len_ok     = (RX_P_Data != '0) && (RX_P_Data <= L_MAX);

  always_comb begin
    alu_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (k_q == K_W'(i)) alu_byte = res_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_buf_q <= '0;
      res_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      burst_q  <= 1'b0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_buf_q <= rd_buf_d;
      res_q    <= res_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_buf_d  = rd_buf_q;
    res_d     = res_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    err_d     = 1'b0;
    wait_rx   = 1'b0;
    ALU_FUN   = '0;
    ALU_EN    = 1'b0;
    CLK_EN    = 1'b0;
    Address   = '0;
    WrEn      = 1'b0;
    RdEn      = 1'b0;
    WrData    = '0;
    TX_P_DATA = '0;
    TX_D_VLD  = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_Data)
            CMD_WR:  state_d = WR_ADDR;
            CMD_RD:  state_d = RD_ADDR;
            CMD_OP:  state_d = OP_A;
            CMD_FN:  state_d = ALU_FN;
            CMD_BW:  state_d = BW_ADDR;
            CMD_BR:  state_d = BR_ADDR;
            default: err_d   = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        wait_rx = 1'b1;
        if (RX_D_VLD) begin
          addr_d  = RX_P_Data[ADDR-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        wait_rx = 1'b1;
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = addr_q;
          WrData  = RX_P_Data;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        wait_rx = 1'b1;
        if (RX_D_VLD) begin
          RdEn    = 1'b1;
          Address = RX_P_Data[ADDR-1:0];
          burst_d = 1'b0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RdData_Valid) begin
          rd_buf_d = RdData;
          state_d  = TX_RD;
        end
      end
      TX_RD: begin
        if (!FIFO_Full) begin
          TX_D_VLD  = 1'b1;
          TX_P_DATA = rd_buf_q;
          if (burst_q && (cnt_q != CNT_ONE)) begin
            addr_d  = addr_q + ADDR_ONE;
            cnt_d   = cnt_q - CNT_ONE;
            state_d = BR_RD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OP_A: begin
        wait_rx = 1'b1;
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          WrData  = RX_P_Data;
          state_d = OP_B;
        end
      end
      OP_B: begin
        wait_rx = 1'b1;
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = ADDR_ONE;
          WrData  = RX_P_Data;
          state_d = ALU_FN;
        end
      end
      ALU_FN: begin
        wait_rx = 1'b1;
        CLK_EN  = 1'b1;
        if (RX_D_VLD) begin
          ALU_EN  = 1'b1;
          ALU_FUN = RX_P_Data[3:0];
          state_d = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        CLK_EN = 1'b1;
        if (Out_Valid) begin
          res_d   = ALU_OUT;
          k_d     = '0;
          state_d = TX_ALU;
        end
      end
      TX_ALU: begin
        if (!FIFO_Full) begin
          TX_D_VLD  = 1'b1;
          TX_P_DATA = alu_byte;
          if (k_q == K_LAST) state_d = IDLE;
          else               k_d     = k_q + K_ONE;
        end
      end
      BW_ADDR, BR_ADDR: begin
        wait_rx = 1'b1;
        if (RX_D_VLD) begin
          addr_d  = RX_P_Data[ADDR-1:0];
          state_d = (state_q == BW_ADDR) ? BW_LEN : BR_LEN;
        end
      end
      BW_LEN, BR_LEN: begin
        wait_rx = 1'b1;
        if (RX_D_VLD) begin
          if (len_ok) begin
            cnt_d   = CNT_W'(RX_P_Data);
            burst_d = (state_q == BR_LEN);
            state_d = (state_q == BW_LEN) ? BW_DATA : BR_RD;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BW_DATA: begin
        wait_rx = 1'b1;
        if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = addr_q;
          WrData  = RX_P_Data;
          addr_d  = addr_q + ADDR_ONE;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = IDLE;
        end
      end
      BR_RD: begin
        RdEn    = 1'b1;
        Address = addr_q;
        state_d = RD_WAIT;
      end
      default: state_d = IDLE;
    endcase

    // No RX activity means no other decision was taken this cycle.
    if (wait_rx && !RX_D_VLD && (tmr_q == '0)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    if ((state_d != state_q) || RX_D_VLD) tmr_d = TMR_LOAD;
    else if (tmr_q != '0)                 tmr_d = tmr_q - TMR_ONE;
    else                                  tmr_d = '0;
  end

endmodule
